// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags. Define
// FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow error outputs.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AW-1:0]    waddr, raddr;
  logic             wr_accept, rd_accept;

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];

  // The extra wrap bit separates "same slot, nothing stored" from "same slot, every slot stored".
  assign empty = (wptr_q == rptr_q);
  assign full  = (waddr == raddr) && (wptr_q[AW] != rptr_q[AW]);

  assign dout = dout_q;

  always_comb begin
    wr_accept = write_en && !full;
    rd_accept = read_en && !empty;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    dout_d    = dout_q;
    if (wr_accept) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rptr_d = rptr_q + PTR_W'(1);
      dout_d = mem_q[raddr];
    end
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem_q[waddr] <= din;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (write_en && full);
    underflow_d = underflow_q || (read_en && empty);
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: directed scenarios then random traffic, each
// cycle checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             CLK;
  logic             rstn;
  logic             write_en;
  logic             read_en;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] mdl_q[$];
  logic [WIDTH-1:0] mdl_dout;
  logic             mdl_ovf;
  logic             mdl_unf;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK      (CLK),
    .rstn     (rstn),
    .write_en (write_en),
    .read_en  (read_en),
    .din      (din),
    .full     (full),
    .empty    (empty),
    .dout     (dout)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_empty"}, 32'(empty), 32'(mdl_q.size() == 0));
    check_output({tag, "_full"},  32'(full),  32'(mdl_q.size() == DEPTH));
    check_output({tag, "_dout"},  32'(dout),  32'(mdl_dout));
`ifdef FIFO_ERR_FLAGS_EN
    check_output({tag, "_ovf"},   32'(overflow),  32'(mdl_ovf));
    check_output({tag, "_unf"},   32'(underflow), 32'(mdl_unf));
`endif
  endtask

  // One clock: drive at posedge+1, update the model on the edge using pre-edge occupancy.
  task automatic apply_stimulus(input logic we, input logic re, input logic [WIDTH-1:0] d,
                                input string tag);
    bit was_full, was_empty;
    write_en = we;
    read_en  = re;
    din      = d;
    @(posedge CLK);
    was_full  = (mdl_q.size() == DEPTH);
    was_empty = (mdl_q.size() == 0);
    if (we && was_full) mdl_ovf = 1'b1;
    if (re && was_empty) mdl_unf = 1'b1;
    if (re && !was_empty) mdl_dout = mdl_q.pop_front();
    if (we && !was_full) mdl_q.push_back(d);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    write_en = 1'b0;
    read_en  = 1'b0;
    #2;
    rstn = 1'b0;
    mdl_q.delete();
    mdl_dout = '0;
    mdl_ovf  = 1'b0;
    mdl_unf  = 1'b0;
    #1;
    check_output({tag, "_empty"}, 32'(empty), 32'd1);
    check_output({tag, "_full"},  32'(full),  32'd0);
    check_output({tag, "_dout"},  32'(dout),  32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check_output({tag, "_ovf"},   32'(overflow),  32'd0);
    check_output({tag, "_unf"},   32'(underflow), 32'd0);
`endif
    #1;
    rstn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] rnd_d;
    int occ;
    rstn     = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    din      = '0;
    mdl_dout = '0;
    mdl_ovf  = 1'b0;
    mdl_unf  = 1'b0;
    #3;
    check_output("init_empty", 32'(empty), 32'd1);
    check_output("init_full",  32'(full),  32'd0);
    check_output("init_dout",  32'(dout),  32'd0);
    rstn = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] overfill");
    for (int k = 0; k < 15; k++) begin
      apply_stimulus(1'b1, 1'b0, WIDTH'(2 * k), "overfill");
      if (k == 6) check_output("overfill_not_full_7", 32'(full), 32'd0);
      if (k == 7) check_output("overfill_full_8", 32'(full), 32'd1);
    end
    check_output("overfill_empty", 32'(empty), 32'd0);

    $display("[TB] drain");
    for (int r = 0; r < 10; r++) begin
      apply_stimulus(1'b0, 1'b1, '0, "drain_rd");
      if (r < 8) check_output("drain_value", 32'(dout), 32'(2 * r));
      if (r == 0) check_output("drain_full_drop", 32'(full), 32'd0);
      if (r == 7) check_output("drain_empty", 32'(empty), 32'd1);
      apply_stimulus(1'b0, 1'b0, '0, "drain_idle");
    end
    check_output("drain_hold14", 32'(dout), 32'd14);

    $display("[TB] wrap");
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, 1'b0, WIDTH'(16'h100 + k), "wrap_wr");
      check_output("wrap_not_empty", 32'(empty), 32'd0);
      apply_stimulus(1'b0, 1'b1, '0, "wrap_rd");
      check_output("wrap_value", 32'(dout), 32'(16'h100 + k));
    end

    $display("[TB] simultaneous");
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b0, WIDTH'(16'h200 + k), "sim_fill4");
    apply_stimulus(1'b1, 1'b1, 16'h2AA, "sim_occ4");
    check_output("sim_occ4_dout", 32'(dout), 32'h200);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b0, WIDTH'(16'h300 + k), "sim_fill8");
    check_output("sim_full", 32'(full), 32'd1);
    apply_stimulus(1'b1, 1'b1, 16'hDEAD, "sim_full_wr_rd");
    check_output("sim_full_after", 32'(full), 32'd0);
    check_output("sim_full_dout", 32'(dout), 32'h201);
    for (int k = 0; k < 7; k++) apply_stimulus(1'b0, 1'b1, '0, "sim_drain");
    check_output("sim_drain_last", 32'(dout), 32'h303);
    check_output("sim_drain_empty", 32'(empty), 32'd1);
    apply_stimulus(1'b1, 1'b1, 16'h4444, "sim_empty_wr_rd");
    check_output("sim_empty_after", 32'(empty), 32'd0);
    check_output("sim_empty_dout", 32'(dout), 32'h303);

`ifdef FIFO_ERR_FLAGS_EN
    $display("[TB] error flags");
    pulse_reset("err_reset");
    apply_stimulus(1'b0, 1'b1, '0, "err_underflow");
    check_output("err_unf_set", 32'(underflow), 32'd1);
    for (int k = 0; k < DEPTH + 1; k++) apply_stimulus(1'b1, 1'b0, WIDTH'(k), "err_fill");
    check_output("err_ovf_set", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) apply_stimulus(1'b0, 1'b1, '0, "err_drain");
    check_output("err_ovf_sticky", 32'(overflow), 32'd1);
    check_output("err_unf_sticky", 32'(underflow), 32'd1);
`endif

    $display("[TB] mid-operation reset");
    for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 1'b0, WIDTH'(16'h500 + k), "mid_fill");
    pulse_reset("mid_reset");
    apply_stimulus(1'b0, 1'b1, '0, "mid_rd_empty");
    check_output("mid_rd_dout", 32'(dout), 32'd0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      occ = mdl_q.size();
      rnd_d = WIDTH'($urandom());
      if (c % 100 == 99) begin
        pulse_reset("rand_reset");
      end else if (c < 200) begin
        apply_stimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4), rnd_d, "rand_a");
      end else begin
        apply_stimulus(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6), rnd_d, "rand_b");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
